logic_capture_port: RTL and testbench
=====================================

Name: logic_capture_port

Overview:
- Per-pod capture endpoint in the LA port clock domain (one instance per logic pod).
- Consumes the trigger controller's trig_rst / capture_en / capture_flush controls after synchronization.
- Packs raw logic samples into wide words for the RAM arbiter FIFO.
- Reports the final partial word, per-run sample count, overflow and completion back toward the trigger logic.

Parameters:
- SAMPLE_WIDTH, 16: bits per input sample (one pod).
- PACK, 8: samples packed per output word.
- COUNT_WIDTH, 32: width of sample_count.

Ports:
- clk  in  1  port sample clock (312.5 MHz).
- rst_n  in  1  asynchronous active-low reset.
- trig_rst  in  1  synchronous run reset from trigger controller (level).
- capture_en  in  1  capture window enable (level).
- capture_flush  in  1  single-cycle flush request.
- sample_din  in  SAMPLE_WIDTH  input sample.
- sample_valid  in  1  sample_din valid this cycle.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream FIFO can accept (not full).
- out_data  out  SAMPLE_WIDTH*PACK  packed samples.
- out_last  out  1  final word of the run.
- out_nsamples  out  $clog2(PACK+1)  valid samples in out_data.
- overflow  out  1  sticky: a word was dropped.
- sample_count  out  COUNT_WIDTH  samples accepted this run.
- done  out  1  final word delivered.

Behaviour:
- Reset (rst_n low, async) and trig_rst high (sync, highest priority over all other inputs):
  - State goes to IDLE.
  - All outputs 0, out_data 0, fill counter 0.
  - Any pending output word is discarded.
- States: IDLE, CAPTURE, WAIT_FLUSH, FLUSH, DONE.
- IDLE:
  - capture_en=1 moves to CAPTURE next cycle.
  - Samples are not accepted in IDLE.
  - capture_flush is ignored in IDLE.
- CAPTURE:
  - Sample accepted when sample_valid && capture_en.
  - Accepted sample k of a word goes to bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]; k=0 is the LSBs.
  - sample_count increments on every accepted sample and wraps at 2^COUNT_WIDTH.
  - capture_en=0 (no flush) moves to WAIT_FLUSH.
  - capture_flush=1 moves to FLUSH. A sample accepted in the same cycle as the flush is included before flushing.
- Word completion (PACK-th accepted sample in cycle N):
  - out_valid=1, out_nsamples=PACK, out_last=0 in cycle N+1.
  - Fill counter returns to 0 in cycle N+1. Sample acceptance continues without a bubble.
- Output handshake:
  - The word transfers on a cycle with out_valid && out_ready.
  - out_valid and out_data are held stable until transfer.
  - Completing a word while the previous word is still pending drops the new word.
  - A dropped word sets overflow (sticky until reset/trig_rst). Its samples still count in sample_count.
- WAIT_FLUSH: accepts no samples. capture_flush moves to FLUSH.
- FLUSH:
  - Waits until no word is pending or the pending word transfers. The final word is never dropped.
  - Then presents the final word: out_last=1, out_nsamples=fill (0..PACK-1), unused lanes zero.
  - fill=0 still emits a marker word: out_nsamples=0, out_data=0.
  - On transfer of the final word: done=1 next cycle, move to DONE.
- DONE:
  - capture_en and capture_flush are ignored.
  - done, sample_count and overflow hold until trig_rst or rst_n.
- sample_count and overflow are readable in every state.

Test Plan:
- Full word: trig_rst pulse, capture_en=1, out_ready=1, 8 samples 0x0001..0x0008.
  - out_valid one cycle after the 8th sample.
  - out_data=0x0008_0007_..._0001, out_nsamples=8, sample_count=8.
- Partial flush: 11 samples, then capture_en=0, then capture_flush.
  - Word 1 has nsamples=8.
  - Word 2 has out_last=1, nsamples=3, upper 5 lanes 0.
  - done=1 after transfer, sample_count=11.
- Backpressure overflow: out_ready=0, 16 continuous samples.
  - First word held stable; second word dropped; overflow=1; sample_count=16.
  - Then out_ready=1 and flush: first word transfers, then last marker with nsamples=0.
- Empty flush: capture_en pulse with no sample_valid, then flush.
  - Single word with out_last=1, nsamples=0, out_data=0; done=1; sample_count=0.
- Simultaneous: 7th sample of a word accepted in the same cycle as capture_flush.
  - Final word has nsamples=7 and contains that sample.
- Mid-run reset:
  - trig_rst with a pending word and fill=5: next cycle out_valid=0, sample_count=0, overflow=0, state IDLE.
  - A new run then operates normally.
  - Repeat with rst_n asserted asynchronously between clock edges: outputs clear immediately.

Source files
------------

// File: rtl/logic_capture_port.sv
// Per-pod capture endpoint: packs accepted logic samples into wide words,
// then emits a final (possibly partial or empty) word when the run is flushed.
module logic_capture_port #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned PACK         = 8,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             trig_rst,
  input  logic                             capture_en,
  input  logic                             capture_flush,
  input  logic [SAMPLE_WIDTH-1:0]          sample_din,
  input  logic                             sample_valid,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SAMPLE_WIDTH*PACK-1:0]     out_data,
  output logic                             out_last,
  output logic [$clog2(PACK+1)-1:0]        out_nsamples,
  output logic                             overflow,
  output logic [COUNT_WIDTH-1:0]           sample_count,
  output logic                             done
);

  localparam int unsigned NS_W   = $clog2(PACK + 1);
  localparam int unsigned WORD_W = SAMPLE_WIDTH * PACK;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CAPTURE    = 3'd1,
    WAIT_FLUSH = 3'd2,
    FLUSH      = 3'd3,
    DONE       = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [NS_W-1:0]        fill_q, fill_d;
  logic [WORD_W-1:0]      acc_q, acc_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_W-1:0]      out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [NS_W-1:0]        out_nsamples_q, out_nsamples_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] sample_count_q, sample_count_d;
  logic                   done_q, done_d;
  logic                   pending;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fill_q         <= '0;
      acc_q          <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      out_nsamples_q <= '0;
      overflow_q     <= 1'b0;
      sample_count_q <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      acc_q          <= acc_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      out_nsamples_q <= out_nsamples_d;
      overflow_q     <= overflow_d;
      sample_count_q <= sample_count_d;
      done_q         <= done_d;
    end
  end

  // Next-state, packing and output-word handshake
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    acc_d          = acc_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    out_nsamples_d = out_nsamples_q;
    overflow_d     = overflow_q;
    sample_count_d = sample_count_q;
    done_d         = done_q;
    // A word is still occupying the output register after this cycle
    pending        = out_valid_q && !out_ready;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (capture_en) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (sample_valid && capture_en) begin
          for (int unsigned k = 0; k < PACK; k++) begin
            if (fill_q == NS_W'(k)) acc_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_din;
          end
          sample_count_d = sample_count_q + COUNT_WIDTH'(1);
          if (fill_q == NS_W'(PACK - 1)) begin
            // Full word: hand it off unless the previous one is still waiting
            if (pending) begin
              overflow_d = 1'b1;
            end else begin
              out_valid_d    = 1'b1;
              out_data_d     = acc_d;
              out_last_d     = 1'b0;
              out_nsamples_d = NS_W'(PACK);
            end
            acc_d  = '0;
            fill_d = '0;
          end else begin
            fill_d = fill_q + NS_W'(1);
          end
        end
        if (capture_flush)    state_d = FLUSH;
        else if (!capture_en) state_d = WAIT_FLUSH;
      end
      WAIT_FLUSH: begin
        if (capture_flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (out_valid_q && out_last_q) begin
          if (out_ready) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (!pending) begin
          // Final word; unused lanes are already zero in the accumulator
          out_valid_d    = 1'b1;
          out_last_d     = 1'b1;
          out_nsamples_d = fill_q;
          out_data_d     = acc_q;
          acc_d          = '0;
          fill_d         = '0;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (trig_rst) begin
      state_d        = IDLE;
      fill_d         = '0;
      acc_d          = '0;
      out_valid_d    = 1'b0;
      out_data_d     = '0;
      out_last_d     = 1'b0;
      out_nsamples_d = '0;
      overflow_d     = 1'b0;
      sample_count_d = '0;
      done_d         = 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign out_nsamples = out_nsamples_q;
  assign overflow     = overflow_q;
  assign sample_count = sample_count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_logic_capture_port.sv
// Bench for logic_capture_port: directed runs with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_logic_capture_port;

  localparam int unsigned SW   = 16;
  localparam int unsigned PACK = 8;
  localparam int unsigned CW   = 32;
  localparam int unsigned NSW  = $clog2(PACK + 1);
  localparam int unsigned WW   = SW * PACK;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            trig_rst, capture_en, capture_flush, sample_valid, out_ready;
  logic [SW-1:0]   sample_din;
  logic            out_valid, out_last, overflow, done;
  logic [WW-1:0]   out_data;
  logic [NSW-1:0]  out_nsamples;
  logic [CW-1:0]   sample_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic_capture_port #(.SAMPLE_WIDTH(SW), .PACK(PACK), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .trig_rst(trig_rst), .capture_en(capture_en),
    .capture_flush(capture_flush), .sample_din(sample_din), .sample_valid(sample_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_nsamples(out_nsamples), .overflow(overflow), .sample_count(sample_count), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 capturing, 2 capture closed, 3 flushing, 4 finished
  int            m_phase;
  logic [SW-1:0] m_word[$];
  logic          m_valid, m_last, m_ovf, m_done;
  logic [WW-1:0] m_data;
  int            m_ns;
  logic [CW-1:0] m_cnt;

  function automatic logic [WW-1:0] pack_word();
    logic [WW-1:0] d = '0;
    foreach (m_word[i]) d[i*SW +: SW] = m_word[i];
    return d;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_word.delete();
    m_valid = 0; m_last = 0; m_ovf = 0; m_done = 0; m_data = '0; m_ns = 0; m_cnt = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || trig_rst) begin
      model_clear();
    end else begin
      logic busy_after, was_final;
      busy_after = m_valid && !out_ready;
      was_final  = m_valid && m_last;
      if (m_valid && out_ready) begin m_valid = 0; m_last = 0; end
      case (m_phase)
        0: if (capture_en) m_phase = 1;
        1: begin
          if (sample_valid && capture_en) begin
            m_word.push_back(sample_din);
            m_cnt++;
            if (m_word.size() == PACK) begin
              if (busy_after) m_ovf = 1;
              else begin m_valid = 1; m_last = 0; m_data = pack_word(); m_ns = PACK; end
              m_word.delete();
            end
          end
          if (capture_flush) m_phase = 3;
          else if (!capture_en) m_phase = 2;
        end
        2: if (capture_flush) m_phase = 3;
        3: begin
          if (was_final) begin
            if (out_ready) begin m_done = 1; m_phase = 4; end
          end else if (!busy_after) begin
            m_valid = 1; m_last = 1; m_ns = m_word.size(); m_data = pack_word();
            m_word.delete();
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", WW'(out_valid), WW'(m_valid));
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_last", WW'(out_last), WW'(m_last));
        chk("out_nsamples", WW'(out_nsamples), WW'(m_ns));
      end
      chk("overflow", WW'(overflow), WW'(m_ovf));
      chk("sample_count", WW'(sample_count), WW'(m_cnt));
      chk("done", WW'(done), WW'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    trig_rst = 0; capture_en = 0; capture_flush = 0; sample_valid = 0; sample_din = '0;
  endtask

  task automatic start_run();
    idle_inputs(); trig_rst = 1; tick();
    trig_rst = 0; capture_en = 1; tick();
  endtask

  task automatic push(input logic [SW-1:0] v);
    sample_valid = 1; sample_din = v; tick();
    sample_valid = 0;
  endtask

  // Runs until done, recording the final word seen on the way
  task automatic wait_done(input int budget, output logic [WW-1:0] fdata, output int fns);
    fdata = '0; fns = -1;
    for (int i = 0; i < budget && !done; i++) begin
      if (out_valid && out_last) begin fdata = out_data; fns = int'(out_nsamples); end
      tick();
    end
    chk("done_reached", WW'(done), WW'(1));
  endtask

  logic [WW-1:0] fd, expw;
  int            fn;

  initial begin
    rst_n = 0; out_ready = 1; idle_inputs();
    tick(); tick();
    rst_n = 1; chk_en = 1;
    chk("rst_out_valid", WW'(out_valid), WW'(0));
    chk("rst_count", WW'(sample_count), WW'(0));
    chk("rst_done", WW'(done), WW'(0));

    // Full word
    start_run();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("no_word_before_8th", WW'(out_valid), WW'(0));
      push(SW'(i));
    end
    chk("full_valid", WW'(out_valid), WW'(1));
    chk("full_data", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("full_ns", WW'(out_nsamples), WW'(8));
    chk("full_count", WW'(sample_count), WW'(8));

    // Partial flush
    start_run();
    for (int i = 1; i <= 11; i++) push(SW'(i));
    capture_en = 0; tick();
    capture_flush = 1; tick(); capture_flush = 0;
    wait_done(20, fd, fn);
    chk("partial_ns", WW'(fn), WW'(3));
    chk("partial_data", fd, 128'h000b_000a_0009);
    chk("partial_count", WW'(sample_count), WW'(11));

    // Backpressure overflow
    start_run(); out_ready = 0;
    for (int i = 1; i <= 16; i++) push(SW'(i));
    chk("bp_overflow", WW'(overflow), WW'(1));
    chk("bp_count", WW'(sample_count), WW'(16));
    chk("bp_held_data", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    capture_en = 0; tick();
    out_ready = 1; capture_flush = 1; tick(); capture_flush = 0;
    wait_done(20, fd, fn);
    chk("bp_marker_ns", WW'(fn), WW'(0));

    // Empty flush
    start_run();
    capture_en = 0; tick();
    capture_flush = 1; tick(); capture_flush = 0;
    wait_done(20, fd, fn);
    chk("empty_ns", WW'(fn), WW'(0));
    chk("empty_data", fd, WW'(0));
    chk("empty_count", WW'(sample_count), WW'(0));

    // Seventh sample together with flush
    start_run();
    for (int i = 1; i <= 6; i++) push(SW'(16'h0a00 + i));
    capture_flush = 1; push(16'h0a07); capture_flush = 0;
    wait_done(20, fd, fn);
    chk("simul_ns", WW'(fn), WW'(7));
    chk("simul_data", fd, 128'h0a07_0a06_0a05_0a04_0a03_0a02_0a01);

    // Mid-run trig_rst with pending word and fill 5
    start_run(); out_ready = 0;
    for (int i = 1; i <= 13; i++) push(SW'(i));
    chk("mid_pending", WW'(out_valid), WW'(1));
    trig_rst = 1; tick(); trig_rst = 0;
    chk("mid_valid", WW'(out_valid), WW'(0));
    chk("mid_count", WW'(sample_count), WW'(0));
    chk("mid_ovf", WW'(overflow), WW'(0));
    out_ready = 1;

    // Mid-run asynchronous rst_n
    start_run(); out_ready = 0;
    for (int i = 1; i <= 13; i++) push(SW'(i));
    #2 rst_n = 0;
    #1;
    chk("async_valid", WW'(out_valid), WW'(0));
    chk("async_count", WW'(sample_count), WW'(0));
    tick(); rst_n = 1; out_ready = 1;

    // Randomized traffic
    idle_inputs();
    for (int c = 0; c < 4000; c++) begin
      trig_rst      = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) capture_en = ~capture_en;
      capture_flush = ($urandom_range(0, 24) == 0);
      sample_valid  = ($urandom_range(0, 3) != 0);
      sample_din    = SW'($urandom);
      out_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
